lms_rx_iq_deframer: RTL and testbench
=====================================

Name: lms_rx_iq_deframer

Overview:
- Sits directly downstream of the IOB capture registers on one LMS6002D RX port (RXnIQSEL/RXnD, lms_clk domain).
- Turns the 12-bit interleaved I/Q bus into MSB-aligned 16-bit I/Q pairs with a one-cycle strobe for the RX frontend.
- Verifies IQSEL framing, reports lock, and counts framing errors.
- Two instances are used, one per LMS RX port.

Parameters:
- LOCK_COUNT, 8: consecutive correct IQSEL alternations needed before lock is declared (range 2..255).
- ERR_WIDTH, 16: width of the saturating framing-error counter.

Ports:
- clk  in  1  lms_clk; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  deframer run; low forces SEARCH.
- swap_iq  in  1  0: iqsel=1 marks the I word; 1: iqsel=0 marks the I word.
- clear_err  in  1  synchronous clear of err_count.
- iqsel  in  1  IQSEL from the IOB register.
- rx_d  in  12  sample word from the IOB register, two's complement.
- i_out  out  16  I sample, {word,4'b0}.
- q_out  out  16  Q sample, {word,4'b0}.
- strobe  out  1  one-cycle valid for i_out/q_out.
- locked  out  1  high in the LOCKED state.
- err_count  out  ERR_WIDTH  saturating count of framing errors since clear.

Behaviour:
- Input stage: iqsel and rx_d are registered once (iqsel_r, d_r). prev_sel holds the previous iqsel_r. isI = iqsel_r XOR swap_iq.
- Alternation check: alt = (iqsel_r != prev_sel).
- Reset values: i_out=0, q_out=0, strobe=0, locked=0, err_count=0. State=SEARCH, alt counter=0, pending-I flag=0, prev_sel=0.
- SEARCH:
  - alt=1: counter increments.
  - alt=0: counter resets to 0.
  - counter reaches LOCK_COUNT-1 and alt=1: go to LOCKED on the next edge and clear pending-I.
  - No strobes are generated in SEARCH.
- LOCKED:
  - isI: capture d_r into the I hold register and set pending-I.
  - !isI with pending-I set: i_out<=I hold, q_out<=d_r, strobe<=1, clear pending-I.
  - !isI with pending-I clear: first word after lock was Q; discard it, no strobe.
  - alt=0: framing error. err_count increments (saturates at all-ones), go to SEARCH with counter=0, clear pending-I, no strobe that cycle.
- Latency: a Q word present on iqsel/rx_d at edge k gives strobe=1 with valid outputs during the cycle after edge k+2. Strobe is never high in two consecutive cycles. When locked and framing is steady, strobe is high every other cycle.
- i_out/q_out hold their last value when strobe=0.
- enable=0: go to SEARCH, counter=0, pending-I=0, strobe=0. The input stage keeps running. err_count is not incremented.
- swap_iq change (detected against a registered copy): go to SEARCH and clear pending-I. This is not counted as an error.
- clear_err has priority over a simultaneous increment; err_count=0 on the next edge.
- rst mid-operation: all state and outputs return to their reset values on the next edge. No strobe is issued for a partial pair.
- locked is asserted in the same cycle the state register reads LOCKED.

Test Plan:
- Reset, enable=1, swap_iq=0, alternate iqsel 1/0 with rx_d I=0x7FF, Q=0x800 -> locked rises after 8 alternations. First strobe follows the first complete I,Q pair; i_out=0x7FF0, q_out=0x8000. Strobe then repeats every 2 cycles.
- While locked, hold iqsel=1 for two consecutive words -> locked=0 next cycle, err_count=1, no strobe. Re-lock after 8 alternations.
- Lock with the first post-lock word being Q -> that word is dropped with no strobe; the next I,Q pair strobes correctly.
- swap_iq=1 with I=0x123 sent while iqsel=0, Q=0x456 while iqsel=1 -> i_out=0x1230, q_out=0x4560. Toggling swap_iq while locked drops lock with err_count unchanged.
- Force 0xFFFF errors, then one more -> err_count stays 0xFFFF. Assert clear_err in the same cycle as an error -> err_count=0.
- Assert rst or drop enable mid-pair, just after an I word -> no strobe, locked=0. With enable held low the outputs hold, and err_count is unchanged by enable=0.

Source files
------------

// File: rtl/lms_rx_iq_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : lms_rx_iq_deframer
//  Purpose  : Deframes the interleaved 12-bit I/Q bus of one LMS6002D RX port
//             (RXnIQSEL/RXnD, lms_clk domain). It checks IQSEL alternation,
//             declares lock, counts framing errors, and presents MSB-aligned
//             16-bit I/Q pairs with a one-cycle strobe.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   lms_clk, rising edge
//    rst        in   synchronous active-high reset
//    enable     in   run; low forces SEARCH and suppresses strobes
//    swap_iq    in   0: iqsel=1 is the I word, 1: iqsel=0 is the I word
//    clear_err  in   synchronous clear of err_count (wins over an increment)
//    iqsel      in   IQSEL from the IOB register
//    rx_d       in   12-bit two's complement sample from the IOB register
//    i_out      out  I sample {word,4'b0}, holds between strobes
//    q_out      out  Q sample {word,4'b0}, holds between strobes
//    strobe     out  one-cycle valid for i_out/q_out
//    locked     out  high while the state register is LOCKED
//    err_count  out  saturating framing-error count
// ============================================================================
module lms_rx_iq_deframer #(
   parameter int LOCK_COUNT = 8,
   parameter int ERR_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 swap_iq,
   input  logic                 clear_err,
   input  logic                 iqsel,
   input  logic [11:0]          rx_d,
   output logic [15:0]          i_out,
   output logic [15:0]          q_out,
   output logic                 strobe,
   output logic                 locked,
   output logic [ERR_WIDTH-1:0] err_count
);

   typedef enum logic [0:0] {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [7:0]           LOCK_LAST = 8'(LOCK_COUNT - 1);
   localparam logic [ERR_WIDTH-1:0] ERR_MAX   = '1;
   localparam logic [ERR_WIDTH-1:0] ERR_ONE   = ERR_WIDTH'(1);

   // input stage
   logic        iqsel_r;
   logic [11:0] d_r;
   logic        prev_sel;
   logic        swap_r;

   // framing state
   state_t      state;
   state_t      state_nxt;
   logic [7:0]  alt_cnt;
   logic [7:0]  cnt_nxt;
   logic        pend_i;
   logic        pend_nxt;
   logic [11:0] i_hold;

   // completed pair, re-registered into the output stage one edge later
   logic        pair_vld;
   logic [11:0] pair_i;
   logic [11:0] pair_q;

   logic        alt;
   logic        is_i;
   logic        swap_chg;
   logic        hold_ld;
   logic        pair_ld;
   logic        err_hit;

   assign alt      = (iqsel_r != prev_sel);
   assign is_i     = iqsel_r ^ swap_iq;
   assign swap_chg = (swap_iq != swap_r);
   assign locked   = (state == LOCKED);

   // ------------------------------------------------------------------------
   // Next-state / control
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = alt_cnt;
      pend_nxt  = pend_i;
      hold_ld   = 1'b0;
      pair_ld   = 1'b0;
      err_hit   = 1'b0;

      // A stopped deframer or a reinterpreted IQSEL polarity invalidates any
      // framing we had; neither is a line error, so nothing is counted.
      if (!enable || swap_chg) begin
         state_nxt = SEARCH;
         cnt_nxt   = 8'd0;
         pend_nxt  = 1'b0;
      end else begin
         case (state)
            SEARCH: begin
               if (alt) begin
                  if (alt_cnt == LOCK_LAST) begin
                     state_nxt = LOCKED;
                     cnt_nxt   = 8'd0;
                     pend_nxt  = 1'b0;
                  end else begin
                     cnt_nxt = alt_cnt + 8'd1;
                  end
               end else begin
                  cnt_nxt = 8'd0;
               end
            end
            LOCKED: begin
               if (!alt) begin
                  err_hit   = 1'b1;
                  state_nxt = SEARCH;
                  cnt_nxt   = 8'd0;
                  pend_nxt  = 1'b0;
               end else if (is_i) begin
                  hold_ld  = 1'b1;
                  pend_nxt = 1'b1;
               end else if (pend_i) begin
                  pair_ld  = 1'b1;
                  pend_nxt = 1'b0;
               end
               // Q with no pending I: first word after lock, dropped.
            end
            default: begin
               state_nxt = SEARCH;
               cnt_nxt   = 8'd0;
               pend_nxt  = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         iqsel_r   <= 1'b0;
         d_r       <= 12'd0;
         prev_sel  <= 1'b0;
         swap_r    <= 1'b0;
         state     <= SEARCH;
         alt_cnt   <= 8'd0;
         pend_i    <= 1'b0;
         i_hold    <= 12'd0;
         pair_vld  <= 1'b0;
         pair_i    <= 12'd0;
         pair_q    <= 12'd0;
         i_out     <= 16'd0;
         q_out     <= 16'd0;
         strobe    <= 1'b0;
         err_count <= '0;
      end else begin
         // the input stage runs regardless of enable
         iqsel_r  <= iqsel;
         d_r      <= rx_d;
         prev_sel <= iqsel_r;
         swap_r   <= swap_iq;

         state    <= state_nxt;
         alt_cnt  <= cnt_nxt;
         pend_i   <= pend_nxt;
         if (hold_ld) begin
            i_hold <= d_r;
         end

         pair_vld <= pair_ld;
         if (pair_ld) begin
            pair_i <= i_hold;
            pair_q <= d_r;
         end

         // gating with enable keeps a pair already in flight from escaping
         // after the deframer has been stopped
         strobe <= pair_vld & enable;
         if (pair_vld && enable) begin
            i_out <= {pair_i, 4'b0000};
            q_out <= {pair_q, 4'b0000};
         end

         if (clear_err) begin
            err_count <= '0;
         end else if (err_hit && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_ONE;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lms_rx_iq_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lms_rx_iq_deframer
//  Purpose  : Directed self-checking bench for lms_rx_iq_deframer. Words are
//             driven on the falling edge; outputs are sampled 1 ns after the
//             rising edge. A 4-bit error counter makes saturation reachable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lms_rx_iq_deframer;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        swap_iq;
   logic        clear_err;
   logic        iqsel;
   logic [11:0] rx_d;
   logic [15:0] i_out;
   logic [15:0] q_out;
   logic        strobe;
   logic        locked;
   logic [3:0]  err_count;

   int   total   = 0;
   int   passed  = 0;
   int   failed  = 0;
   logic cur_sel = 1'b0;

   always #5 clk = ~clk;

   lms_rx_iq_deframer #(
      .LOCK_COUNT (8),
      .ERR_WIDTH  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .swap_iq   (swap_iq),
      .clear_err (clear_err),
      .iqsel     (iqsel),
      .rx_d      (rx_d),
      .i_out     (i_out),
      .q_out     (q_out),
      .strobe    (strobe),
      .locked    (locked),
      .err_count (err_count)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one word: drive on the falling edge, return 1 ns after the rising edge
   task automatic send(input logic sel, input logic [11:0] d);
      @(negedge clk);
      iqsel   = sel;
      rx_d    = d;
      cur_sel = sel;
      @(posedge clk);
      #1;
   endtask

   // n correctly alternating words; d1 goes with iqsel=1, d0 with iqsel=0
   task automatic alt_words(input int n, input logic [11:0] d1, input logic [11:0] d0);
      for (int j = 0; j < n; j++) begin
         logic s;
         s = ~cur_sel;
         send(s, s ? d1 : d0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; enable = 1'b0; swap_iq = 1'b0; clear_err = 1'b0;
      iqsel = 1'b0; rx_d = 12'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_i_out",  i_out,  16'h0000);
      check("rst_q_out",  q_out,  16'h0000);
      check("rst_strobe", strobe, 16'h0000);
      check("rst_locked", locked, 16'h0000);
      check("rst_err",    err_count, 16'h0000);
      rst = 1'b0; enable = 1'b1;

      // ---- lock with I=0x7FF (iqsel=1), Q=0x800 (iqsel=0) ----
      alt_words(8, 12'h7FF, 12'h800);
      check("lock_w8_not_yet", locked, 16'h0);
      alt_words(1, 12'h7FF, 12'h800);
      check("lock_w9_locked", locked, 16'h1);
      alt_words(2, 12'h7FF, 12'h800);
      check("first_pair_no_strobe_yet", strobe, 16'h0);
      alt_words(1, 12'h7FF, 12'h800);
      check("first_strobe", strobe, 16'h1);
      check("first_i", i_out, 16'h7FF0);
      check("first_q", q_out, 16'h8000);
      alt_words(1, 12'h7FF, 12'h800);
      check("strobe_gap", strobe, 16'h0);
      alt_words(1, 12'h7FF, 12'h800);
      check("strobe_repeat", strobe, 16'h1);

      // ---- framing error: two I words back to back ----
      alt_words(1, 12'h7FF, 12'h800);      // I
      send(1'b1, 12'h7FF);                 // duplicate I
      check("err_prev_pair_strobe", strobe, 16'h1);
      alt_words(1, 12'h7FF, 12'h800);
      check("err_unlocked", locked, 16'h0);
      check("err_count_1", err_count, 16'h1);
      check("err_no_strobe", strobe, 16'h0);
      alt_words(1, 12'h7FF, 12'h800);
      check("err_no_strobe_2", strobe, 16'h0);
      alt_words(6, 12'h7FF, 12'h800);
      check("relock_not_yet", locked, 16'h0);

      // ---- first word after lock is Q: dropped ----
      send(1'b0, 12'h111);
      check("relock_locked", locked, 16'h1);
      send(1'b1, 12'h222);
      send(1'b0, 12'h333);
      check("dropped_q_no_strobe", strobe, 16'h0);
      send(1'b1, 12'h444);
      check("pair_pending_no_strobe", strobe, 16'h0);
      send(1'b0, 12'h555);
      check("after_drop_strobe", strobe, 16'h1);
      check("after_drop_i", i_out, 16'h2220);
      check("after_drop_q", q_out, 16'h3330);

      // ---- swap_iq toggled while locked, then lock with swapped polarity ----
      swap_iq = 1'b1;
      alt_words(1, 12'h456, 12'h123);
      check("swap_unlocked", locked, 16'h0);
      check("swap_err_same", err_count, 16'h1);
      check("swap_i_hold", i_out, 16'h2220);
      alt_words(1, 12'h456, 12'h123);
      check("swap_no_strobe", strobe, 16'h0);
      alt_words(6, 12'h456, 12'h123);
      check("swap_relock_not_yet", locked, 16'h0);
      alt_words(1, 12'h456, 12'h123);
      check("swap_relocked", locked, 16'h1);
      alt_words(3, 12'h456, 12'h123);
      check("swap_no_strobe_yet", strobe, 16'h0);
      alt_words(1, 12'h456, 12'h123);
      check("swap_strobe", strobe, 16'h1);
      check("swap_i", i_out, 16'h1230);
      check("swap_q", q_out, 16'h4560);
      check("swap_err_still_1", err_count, 16'h1);

      // ---- drive err_count to saturation (4-bit, max 0xF) ----
      for (int e = 0; e < 14; e++) begin
         send(cur_sel, 12'h000);
         alt_words(8, 12'h456, 12'h123);
      end
      check("sat_err_15", err_count, 16'hF);
      send(cur_sel, 12'h000);
      check("sat_locked_before_err", locked, 16'h1);
      alt_words(1, 12'h456, 12'h123);
      check("sat_err_stays", err_count, 16'hF);
      check("sat_unlocked", locked, 16'h0);

      // ---- clear_err alone, then together with an error ----
      clear_err = 1'b1;
      alt_words(1, 12'h456, 12'h123);
      clear_err = 1'b0;
      check("clear_err", err_count, 16'h0);
      alt_words(7, 12'h456, 12'h123);
      check("clr_locked", locked, 16'h1);
      send(cur_sel, 12'h000);
      clear_err = 1'b1;
      alt_words(1, 12'h456, 12'h123);
      clear_err = 1'b0;
      check("clear_beats_inc", err_count, 16'h0);
      check("clear_err_unlocked", locked, 16'h0);

      // ---- rst just after an I word ----
      alt_words(8, 12'h456, 12'h123);
      check("pre_rst_locked", locked, 16'h1);
      alt_words(1, 12'h456, 12'h123);      // Q first, dropped
      alt_words(1, 12'h456, 12'h123);      // I, pending
      rst = 1'b1;
      alt_words(1, 12'h0AB, 12'hF00);
      rst = 1'b0;
      check("rst_mid_locked", locked, 16'h0);
      check("rst_mid_strobe", strobe, 16'h0);
      check("rst_mid_i", i_out, 16'h0000);
      check("rst_mid_q", q_out, 16'h0000);
      alt_words(1, 12'h0AB, 12'hF00);
      check("post_rst_no_strobe_1", strobe, 16'h0);
      alt_words(1, 12'h0AB, 12'hF00);
      check("post_rst_no_strobe_2", strobe, 16'h0);

      // ---- relock (swap still 1), then drop enable just after an I word ----
      alt_words(6, 12'h0AB, 12'hF00);
      check("en_relock_not_yet", locked, 16'h0);
      alt_words(1, 12'h0AB, 12'hF00);
      check("en_relocked", locked, 16'h1);
      alt_words(4, 12'h0AB, 12'hF00);
      check("en_strobe", strobe, 16'h1);
      check("en_i", i_out, 16'hF000);
      check("en_q", q_out, 16'h0AB0);
      alt_words(1, 12'h0AB, 12'hF00);      // I
      alt_words(1, 12'h0AB, 12'hF00);      // Q, previous pair strobes
      check("en_last_strobe", strobe, 16'h1);
      enable = 1'b0;
      alt_words(1, 12'h111, 12'h222);
      check("en_low_unlocked", locked, 16'h0);
      check("en_low_no_strobe", strobe, 16'h0);
      send(cur_sel, 12'h333);
      check("en_low_no_strobe_2", strobe, 16'h0);
      alt_words(2, 12'h111, 12'h222);
      check("en_low_no_strobe_3", strobe, 16'h0);
      check("en_low_i_hold", i_out, 16'hF000);
      check("en_low_q_hold", q_out, 16'h0AB0);
      check("en_low_err", err_count, 16'h0);
      check("en_low_still_unlocked", locked, 16'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
